// File: rtl/c2f_dsc_ring_reader.sv
// rtl/c2f_dsc_ring_reader.sv - host descriptor ring fetch engine
// Watches the software tail, issues BAS burst reads and streams one descriptor per returned flit.
module c2f_dsc_ring_reader #(
  parameter int MAX_BURST  = 8,
  parameter int FIFO_DEPTH = 32,
  parameter int RB_AWIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tail_wr,
  input  logic [31:0]          tail_wr_data,
  input  logic [63:0]          rb_base_addr,
  input  logic [RB_AWIDTH:0]   rb_size,
  input  logic                 pcie_bas_waitrequest,
  output logic [63:0]          pcie_bas_address,
  output logic                 pcie_bas_read,
  output logic [3:0]           pcie_bas_burstcount,
  input  logic [511:0]         pcie_bas_readdata,
  input  logic                 pcie_bas_readdatavalid,
  output logic [511:0]         out_dsc_data,
  output logic                 out_dsc_valid,
  input  logic                 out_dsc_ready,
  output logic [RB_AWIDTH-1:0] head,
  output logic [31:0]          spurious_rsp_cnt
);

  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam int CW  = FAW + 1;
  localparam int IW  = RB_AWIDTH + 1;

  localparam logic [CW-1:0]        DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]        C_ONE   = CW'(1);
  localparam logic [CW-1:0]        C_ZERO  = '0;
  localparam logic [FAW-1:0]       F_ONE   = FAW'(1);
  localparam logic [IW-1:0]        MAX_C   = IW'(MAX_BURST);
  localparam logic [RB_AWIDTH-1:0] I_ONE   = RB_AWIDTH'(1);

  typedef enum logic [0:0] {S_IDLE, S_REQ} state_t;

  state_t                 state_q, state_d;
  logic [RB_AWIDTH-1:0]   tail_q, tail_d;
  logic [RB_AWIDTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [RB_AWIDTH-1:0]   head_q, head_d;
  logic [CW-1:0]          out_q, out_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [FAW-1:0]         wptr_q, wptr_d;
  logic [FAW-1:0]         rptr_q, rptr_d;
  logic [63:0]            addr_q, addr_d;
  logic [3:0]             burst_q, burst_d;
  logic                   read_q, read_d;
  logic [31:0]            spur_q, spur_d;

  logic [511:0]           mem [FIFO_DEPTH];

  logic [RB_AWIDTH-1:0]   mask_lo;
  logic [RB_AWIDTH-1:0]   unissued;
  logic [IW-1:0]          to_wrap;
  logic [CW-1:0]          credits;
  logic [IW-1:0]          burst_w;
  logic [CW-1:0]          issue_amt;
  logic                   beat_ok;
  logic                   beat_spur;
  logic                   pop;
  logic                   unused_tail_hi;

  assign unused_tail_hi = ^tail_wr_data[31:RB_AWIDTH];

  // rb_size is a power of two, so its low bits minus one give the index mask even at 2^RB_AWIDTH
  assign mask_lo   = rb_size[RB_AWIDTH-1:0] - I_ONE;
  assign unissued  = (tail_q - rd_ptr_q) & mask_lo;
  assign to_wrap   = rb_size - {1'b0, rd_ptr_q};
  assign credits   = DEPTH_C - cnt_q - out_q;
  assign beat_ok   = pcie_bas_readdatavalid && (out_q != C_ZERO);
  assign beat_spur = pcie_bas_readdatavalid && (out_q == C_ZERO);
  assign pop       = (cnt_q != C_ZERO) && out_dsc_ready;

  always_comb begin
    burst_w = {1'b0, unissued};
    if (to_wrap < burst_w) burst_w = to_wrap;
    if (burst_w > MAX_C) burst_w = MAX_C;
    if (burst_w > IW'(credits)) burst_w = IW'(credits);
  end

  always_comb begin
    state_d   = state_q;
    tail_d    = tail_q;
    rd_ptr_d  = rd_ptr_q;
    head_d    = head_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    addr_d    = addr_q;
    burst_d   = burst_q;
    read_d    = read_q;
    spur_d    = spur_q;
    issue_amt = C_ZERO;

    if (tail_wr) tail_d = tail_wr_data[RB_AWIDTH-1:0] & mask_lo;

    case (state_q)
      S_IDLE: begin
        if ((unissued != '0) && (credits != C_ZERO)) begin
          issue_amt = CW'(burst_w);
          read_d    = 1'b1;
          addr_d    = rb_base_addr + 64'({rd_ptr_q, 6'b0});
          burst_d   = burst_w[3:0];
          rd_ptr_d  = (rd_ptr_q + burst_w[RB_AWIDTH-1:0]) & mask_lo;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        // Acceptance always returns through IDLE, which guarantees a gap cycle between requests
        if (!pcie_bas_waitrequest) begin
          read_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    out_d = out_q + issue_amt - (beat_ok ? C_ONE : C_ZERO);
    cnt_d = cnt_q + (beat_ok ? C_ONE : C_ZERO) - (pop ? C_ONE : C_ZERO);
    if (beat_ok) wptr_d = wptr_q + F_ONE;
    if (pop) begin
      rptr_d = rptr_q + F_ONE;
      head_d = (head_q + I_ONE) & mask_lo;
    end
    if (beat_spur && (spur_q != 32'hFFFF_FFFF)) spur_d = spur_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      tail_q   <= '0;
      rd_ptr_q <= '0;
      head_q   <= '0;
      out_q    <= '0;
      cnt_q    <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      addr_q   <= '0;
      burst_q  <= '0;
      read_q   <= 1'b0;
      spur_q   <= '0;
    end else begin
      state_q  <= state_d;
      tail_q   <= tail_d;
      rd_ptr_q <= rd_ptr_d;
      head_q   <= head_d;
      out_q    <= out_d;
      cnt_q    <= cnt_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      addr_q   <= addr_d;
      burst_q  <= burst_d;
      read_q   <= read_d;
      spur_q   <= spur_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && beat_ok) mem[wptr_q] <= pcie_bas_readdata;
  end

  assign pcie_bas_address    = addr_q;
  assign pcie_bas_read       = read_q;
  assign pcie_bas_burstcount = burst_q;
  assign out_dsc_valid       = (cnt_q != C_ZERO);
  assign out_dsc_data        = out_dsc_valid ? mem[rptr_q] : '0;
  assign head                = head_q;
  assign spurious_rsp_cnt    = spur_q;

endmodule
